dff_resp_checker: RTL

DFF_RESP_CHECKER -- requirements
Module: dff_resp_checker

---
 rtl/dff_chk_pkg.sv | 31 +++
 rtl/chk_fifo.sv | 59 +++++
 rtl/dff_resp_checker.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/dff_chk_pkg.sv
// Shared types for the flip-flop response checker.
// DFF_CHK_TIMESTAMP_EN adds a 16-bit cycle timestamp to every mismatch record.
package dff_chk_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WARM  = 2'd1,
      ST_CHECK = 2'd2,
      ST_HALT  = 2'd3
   } chk_state_e;

   localparam int TS_W = 16;

`ifdef DFF_CHK_TIMESTAMP_EN
   localparam int REC_W = 18;

   typedef struct packed {
      logic [TS_W-1:0] ts;
      logic            expected;
      logic            observed;
   } rec_t;
`else
   localparam int REC_W = 2;

   typedef struct packed {
      logic expected;
      logic observed;
   } rec_t;
`endif

endpackage

// File: rtl/chk_fifo.sv
// Synchronous record FIFO; a push into a full FIFO is taken only when a pop
// happens in the same cycle.
module chk_fifo #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   // Pointers carry one extra wrap bit to tell full from empty.
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             do_pop;
   logic             do_push;

   always_comb begin
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      pop_data = mem_q[rd_ptr_q[AW-1:0]];
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (do_push) begin
         mem_d[wr_ptr_q[AW-1:0]] = push_data;
         wr_ptr_d                = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/dff_resp_checker.sv
// Checks a flip-flop's Q against a LATENCY-stage reference model and buffers mismatches.
// DFF_CHK_TIMESTAMP_EN adds a cycle timestamp (start cycle = 0) to each record.
module dff_resp_checker
   import dff_chk_pkg::*;
#(
   parameter int LATENCY    = 1,
   parameter int WARMUP     = 2,
   parameter int FIFO_DEPTH = 8,
   parameter int MAX_ERR    = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             d_in,
   input  logic             arst_in,
   input  logic             q_obs,
   output logic             rec_valid,
   input  logic             rec_ready,
   output logic [REC_W-1:0] rec_data,
   output logic [7:0]       err_count,
   output logic             overflow,
   output logic             done,
   output logic [1:0]       state
);

   localparam logic [3:0] WARM_LAST = (WARMUP == 0) ? 4'd0 : 4'(WARMUP - 1);
   localparam logic [8:0] MAX_ERR_V = 9'(MAX_ERR);

   chk_state_e         state_q, state_d;
   logic [3:0]         warm_cnt_q, warm_cnt_d;
   logic [LATENCY-1:0] stage_q, stage_d;
   logic [7:0]         err_q, err_d;
   logic               ovf_q, ovf_d;
   logic               expected;
   logic               mismatch;
   logic               start_acc;
   logic               fifo_full;
   logic               fifo_empty;
   logic               pop;
   rec_t               rec;
`ifdef DFF_CHK_TIMESTAMP_EN
   logic [TS_W-1:0]    ts_q, ts_d;
`endif

   // Reference model: arst_in forces Q low now and flushes every stage.
   always_comb begin
      expected   = arst_in ? 1'b0 : stage_q[LATENCY-1];
      stage_d    = stage_q;
      stage_d[0] = d_in;
      for (int i = 1; i < LATENCY; i++) begin
         stage_d[i] = stage_q[i-1];
      end
      if (arst_in) begin
         stage_d = '0;
      end
   end

   always_comb begin
      state_d    = state_q;
      warm_cnt_d = warm_cnt_q;
      start_acc  = 1'b0;
      mismatch   = (state_q == ST_CHECK) && (q_obs != expected);
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               start_acc  = 1'b1;
               warm_cnt_d = '0;
               state_d    = (WARMUP == 0) ? ST_CHECK : ST_WARM;
            end
         end
         ST_WARM: begin
            if (warm_cnt_q == WARM_LAST) begin
               state_d = ST_CHECK;
            end else begin
               warm_cnt_d = warm_cnt_q + 4'd1;
            end
         end
         ST_CHECK: begin
            if (mismatch && ({1'b0, err_q} + 9'd1 >= MAX_ERR_V)) begin
               state_d = ST_HALT;
            end
         end
         ST_HALT: begin
            if (start) begin
               start_acc = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // err/overflow only ever become nonzero in CHECK, so clearing on any accepted start is safe.
   always_comb begin
      pop   = !fifo_empty && rec_ready;
      err_d = err_q;
      ovf_d = ovf_q;
      if (start_acc) begin
         err_d = '0;
         ovf_d = 1'b0;
      end else if (mismatch) begin
         if (err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
         end
         if (fifo_full && !pop) begin
            ovf_d = 1'b1;
         end
      end
   end

`ifdef DFF_CHK_TIMESTAMP_EN
   always_comb begin
      ts_d         = start_acc ? 16'd1 : ts_q + 16'd1;
      rec.ts       = ts_q;
      rec.expected = expected;
      rec.observed = q_obs;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ts_q <= '0;
      end else begin
         ts_q <= ts_d;
      end
   end
`else
   always_comb begin
      rec.expected = expected;
      rec.observed = q_obs;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         warm_cnt_q <= '0;
         stage_q    <= '0;
         err_q      <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         warm_cnt_q <= warm_cnt_d;
         stage_q    <= stage_d;
         err_q      <= err_d;
         ovf_q      <= ovf_d;
      end
   end

   chk_fifo #(
      .WIDTH (REC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (mismatch),
      .push_data (rec),
      .pop       (pop),
      .pop_data  (rec_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_comb begin
      rec_valid = !fifo_empty;
      err_count = err_q;
      overflow  = ovf_q;
      done      = (state_q == ST_HALT);
      state     = state_q;
   end

endmodule
